pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline buffer between CPU stages.
- Replaces fixed single-entry stall registers with a ready/valid FIFO of DEPTH entries.
- Adds a synchronous flush and a freeze input.
- Instantiated per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with WIDTH set to the packed stage bus width.

---
 rtl/pipe_stage_buf.sv | 106 ++++++++++
 tb/tb_pipe_stage_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Elastic ready/valid pipeline buffer (DEPTH-entry circular FIFO)
//            with synchronous flush and freeze. Optional debug sideband is
//            enabled by defining PIPE_BUF_DEBUG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
`ifdef PIPE_BUF_DEBUG_EN
    ,
    parameter int DBG_WIDTH = 64
`endif
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
`ifdef PIPE_BUF_DEBUG_EN
    input  logic [DBG_WIDTH-1:0] dbg_in,
    output logic [DBG_WIDTH-1:0] dbg_out,
`endif
    output logic [CNT_W-1:0] count
);

    // A single-entry buffer still needs a one-bit pointer to stay legal.
    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Handshake depends only on registered occupancy and stall.
    assign in_ready  = (r_count != C_FULL) & ~stall;
    assign out_valid = (r_count != '0) & ~stall;
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Storage is deliberately left intact; only the bookkeeping clears.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PIPE_BUF_DEBUG_EN
    logic [DBG_WIDTH-1:0] r_dbg_mem [DEPTH];

    assign dbg_out = r_dbg_mem[r_rd_ptr];

    // Sideband rides in lockstep with the payload write pointer.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dbg_mem[i] <= '0;
            end
        end else if (!flush && w_push) begin
            r_dbg_mem[r_wr_ptr] <= dbg_in;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: DEPTH=2 and DEPTH=1 instances, vector table
// plus streaming, freeze, flush and mid-transfer reset sequences.
`default_nettype none

module tb_pipe_stage_buf;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         a_iv, a_or, a_st, a_fl, a_ir, a_ov;
    logic [W-1:0] a_id, a_od;
    logic [1:0]   a_cnt;
    logic         b_iv, b_or, b_st, b_fl, b_ir, b_ov;
    logic [W-1:0] b_id, b_od;
    logic [0:0]   b_cnt;
`ifdef PIPE_BUF_DEBUG_EN
    logic [63:0]  a_dbo, b_dbo;
`endif

    pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) u_dut2 (
        .ACLK(clk), .ARESETn(rstn),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .stall(a_st), .flush(a_fl),
`ifdef PIPE_BUF_DEBUG_EN
        .dbg_in(64'(a_id)), .dbg_out(a_dbo),
`endif
        .count(a_cnt)
    );

    pipe_stage_buf #(.WIDTH(W), .DEPTH(1)) u_dut1 (
        .ACLK(clk), .ARESETn(rstn),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .stall(b_st), .flush(b_fl),
`ifdef PIPE_BUF_DEBUG_EN
        .dbg_in(64'(b_id)), .dbg_out(b_dbo),
`endif
        .count(b_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int a_outs = 0;
    int b_outs = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate the current cycle mid-period, update scoreboards, advance one clock.
    task automatic step();
        #1;
        chk("a_count_bound", W'(a_cnt <= 2'd2), 1);
        if (a_ov && a_or) begin
            a_outs++;
            if (qa.size() == 0) chk("a_unexpected_out", a_od, 'x);
            else chk("a_sb_data", a_od, qa.pop_front());
        end
        if (a_fl) qa.delete();
        else if (a_iv && a_ir) qa.push_back(a_id);

        if (b_ov && b_or) begin
            b_outs++;
            if (qb.size() == 0) chk("b_unexpected_out", b_od, 'x);
            else chk("b_sb_data", b_od, qb.pop_front());
        end
        if (b_fl) qb.delete();
        else if (b_iv && b_ir) qb.push_back(b_id);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         rdy;
        logic         st;
        logic         fl;
        logic         e_ov;
        logic         e_ir;
        logic [1:0]   e_cnt;
        logic         chk_od;
        logic [W-1:0] e_od;
    } vec_t;

    vec_t vt[18];

    initial begin
        //           iv  data          rdy st fl   ov ir cnt  chk od
        vt[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0};
        vt[1]  = '{1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0};
        vt[2]  = '{1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hA5A50001};
        vt[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'hA5A50001};
        vt[4]  = '{1'b1, 32'h3,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'hA5A50001};
        vt[5]  = '{1'b1, 32'h3,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'hA5A50001};
        vt[6]  = '{1'b1, 32'h3,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'hA5A50001};
        vt[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'hA5A50001};
        vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h2};
        vt[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};
        vt[10] = '{1'b1, 32'h11,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};
        vt[11] = '{1'b1, 32'h22,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h11};
        vt[12] = '{1'b1, 32'h77,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 32'h11};
        vt[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};
        vt[14] = '{1'b1, 32'h77,       1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};
        vt[15] = '{1'b1, 32'h88,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};
        vt[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h88};
        vt[17] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};

        a_iv = 0; a_or = 0; a_st = 0; a_fl = 0; a_id = '0;
        b_iv = 0; b_or = 0; b_st = 0; b_fl = 0; b_id = '0;

        // Outputs while held in reset, with and without stall.
        #1;
        chk("rst_out_valid", W'(a_ov), 0);
        chk("rst_in_ready", W'(a_ir), 1);
        chk("rst_count", W'(a_cnt), 0);
        chk("rst_out_data", a_od, 0);
        a_st = 1;
        #1;
        chk("rst_in_ready_stall", W'(a_ir), 0);
        a_st = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors on the DEPTH=2 instance.
        for (int i = 0; i < 18; i++) begin
            a_iv = vt[i].iv; a_id = vt[i].d; a_or = vt[i].rdy;
            a_st = vt[i].st; a_fl = vt[i].fl;
            #1;
            chk($sformatf("vec%0d_out_valid", i), W'(a_ov), W'(vt[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), W'(a_ir), W'(vt[i].e_ir));
            chk($sformatf("vec%0d_count", i), W'(a_cnt), W'(vt[i].e_cnt));
            if (vt[i].chk_od) chk($sformatf("vec%0d_out_data", i), a_od, vt[i].e_od);
            step();
        end
        a_st = 0; a_fl = 0;

        // Full-rate streaming through DEPTH=2.
        a_outs = 0;
        for (int i = 1; i <= 100; i++) begin
            a_iv = 1; a_id = W'(i); a_or = 1;
            #1;
            if (i > 1) begin
                chk("a_stream_count", W'(a_cnt), 1);
                chk("a_stream_out_valid", W'(a_ov), 1);
            end
            step();
        end
        a_iv = 0;
        step();
        chk("a_stream_outputs", W'(a_outs), 100);
        chk("a_stream_drained", W'(a_cnt), 0);
        a_or = 0;

        // Half-rate streaming through DEPTH=1.
        begin
            int idx = 1;
            int cyc = 0;
            b_outs = 0;
            while (idx <= 100 && cyc < 400) begin
                b_iv = 1; b_id = W'(idx); b_or = 1;
                #1;
                chk("b_in_ready_toggle", W'(b_ir), W'(cyc % 2 == 0));
                if (b_ir) idx++;
                step();
                cyc++;
            end
            chk("b_all_accepted", W'(idx), 101);
            b_iv = 0;
            step();
            chk("b_stream_outputs", W'(b_outs), 100);
            chk("b_stream_drained", W'(b_cnt), 0);
            b_or = 0;
        end

        // Reset dropped mid-transfer, then fresh operation.
        a_iv = 1; a_id = 32'h55; step();
        a_id = 32'h66; step();
        a_iv = 0;
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_count", W'(a_cnt), 0);
        chk("midrst_out_valid", W'(a_ov), 0);
        chk("midrst_out_data", a_od, 0);
        chk("midrst_in_ready", W'(a_ir), 1);
        qa.delete();
        @(negedge clk);
        rstn = 1'b1;
        a_iv = 1; a_id = 32'h99; step();
        a_iv = 0; a_or = 1;
        #1;
        chk("postrst_out_valid", W'(a_ov), 1);
        chk("postrst_out_data", a_od, 32'h99);
        step();
        chk("postrst_sb_empty", W'(qa.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
